// File: rtl/mips_div_iter.sv
// Iterative radix-2 restoring divider (DIV/DIVU) for the MIPS E stage; raises div_stall while busy.
// Optional `define DIV_EARLY_OUT_EN finishes in one cycle when |b| == 0 or |a| < |b|.
module mips_div_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             annul,
  input  logic             hold,
  output logic             div_stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} divState_t;

  divState_t        state, stateNext;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] divisor, remAcc, quoAcc;
  logic             signQ, signR;
  logic             signQIn, signRIn;
  logic [WIDTH-1:0] absA, absB;
  logic             accept, lastStep, earlyOut;
  logic [WIDTH:0]   shifted, trial;
  logic             trialOk;
  logic [WIDTH-1:0] remNext, quoNext;

  function automatic logic [WIDTH-1:0] applySign(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign signQIn  = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
  assign signRIn  = signed_div & a[WIDTH-1];
  assign absA     = applySign(signRIn, a);
  assign absB     = applySign(signed_div & b[WIDTH-1], b);
  assign accept   = (state == IDLE) & start & ~annul;
  assign lastStep = (cnt == CNT_W'(WIDTH - 1));

  // Partial remainder is always below the divisor, so bit WIDTH of the trial is its sign.
  assign shifted  = {remAcc, quoAcc[WIDTH-1]};
  assign trial    = shifted - {1'b0, divisor};
  assign trialOk  = ~trial[WIDTH];
  assign remNext  = trialOk ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quoNext  = {quoAcc[WIDTH-2:0], trialOk};

`ifdef DIV_EARLY_OUT_EN
  assign earlyOut = (absB == '0) | (absA < absB);
`else
  assign earlyOut = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext    = state;
    div_stall    = 1'b0;
    result_valid = 1'b0;
    case (state)
      IDLE: begin
        div_stall = start & resetn;
        if (start) stateNext = earlyOut ? DONE : BUSY;
      end
      BUSY: begin
        div_stall = 1'b1;
        if (lastStep) stateNext = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        if (!hold) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    // A flush of E wins over everything, including a start in the same cycle.
    if (annul) begin
      stateNext    = IDLE;
      div_stall    = 1'b0;
      result_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      divisor <= absB;
      quoAcc  <= absA;
      remAcc  <= '0;
      signQ   <= signQIn;
      signR   <= signRIn;
    end else if (state == BUSY) begin
      remAcc  <= remNext;
      quoAcc  <= quoNext;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      if (accept)              cnt <= '0;
      else if (state == BUSY)  cnt <= cnt + 1'b1;

      if ((state == BUSY) && lastStep && !annul) begin
        quotient  <= applySign(signQ, quoNext);
        remainder <= applySign(signR, remNext);
      end
`ifdef DIV_EARLY_OUT_EN
      else if (accept && earlyOut) begin
        quotient  <= (absB == '0) ? applySign(signQIn, '1) : '0;
        remainder <= a;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mips_div_iter.sv
// Scoreboard bench for mips_div_iter: expected quotient/remainder queued at issue, compared at result_valid.
module tb_mips_div_iter;
  logic        clk = 1'b0;
  logic        resetn;
  logic        start, signed_div, annul, hold;
  logic [31:0] a, b;
  logic        div_stall, result_valid;
  logic [31:0] quotient, remainder;

  int nCompared   = 0;
  int nMismatched = 0;
  logic [63:0] sb[$];

  mips_div_iter #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .resetn(resetn), .start(start), .signed_div(signed_div),
    .a(a), .b(b), .annul(annul), .hold(hold),
    .div_stall(div_stall), .result_valid(result_valid),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] q, r;
    if (!sgn) begin
      if (y == 0) begin q = 32'hFFFF_FFFF; r = x; end
      else begin q = x / y; r = x % y; end
    end else if (y == 0) begin
      q = x[31] ? 32'd1 : 32'hFFFF_FFFF; r = x;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else begin
      q = $signed(x) / $signed(y);
      r = $signed(x) % $signed(y);
    end
    return {q, r};
  endfunction

  function automatic int expStall(input logic sgn, input logic [31:0] x, input logic [31:0] y);
`ifdef DIV_EARLY_OUT_EN
    logic [31:0] mx, my;
    mx = (sgn && x[31]) ? -x : x;
    my = (sgn && y[31]) ? -y : y;
    if (my == 0 || mx < my) return 1;
`endif
    return 33;
  endfunction

  task automatic runDiv(input logic sgn, input logic [31:0] x, input logic [31:0] y, input int holdN);
    int stalls = 0;
    logic seen = 1'b0;
    logic [63:0] exp;
    sb.push_back(model(sgn, x, y));
    @(posedge clk); #1;
    start = 1'b1; signed_div = sgn; a = x; b = y; hold = (holdN > 0);
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (result_valid) seen = 1'b1;
      else if (div_stall) stalls++;
    end
    checkVal("timeout", {63'd0, seen}, 64'd1);
    checkVal("stallCycles", 64'(stalls), 64'(expStall(sgn, x, y)));
    exp = sb.pop_front();
    checkVal("quotient", {32'd0, quotient}, {32'd0, exp[63:32]});
    checkVal("remainder", {32'd0, remainder}, {32'd0, exp[31:0]});
    for (int i = 0; i < holdN; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checkVal("holdValid", {63'd0, result_valid}, 64'd1);
      checkVal("holdStall", {63'd0, div_stall}, 64'd0);
      checkVal("holdQuo", {quotient, remainder}, exp);
    end
    if (holdN > 0) begin
      @(posedge clk); #1; hold = 1'b0;
      @(negedge clk);
      checkVal("lastDoneValid", {63'd0, result_valid}, 64'd1);
    end
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    checkVal("idleValid", {63'd0, result_valid}, 64'd0);
    checkVal("idleStall", {63'd0, div_stall}, 64'd0);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; signed_div = 1'b0; annul = 1'b0; hold = 1'b0;
    a = '0; b = '0;
    #12;
    checkVal("rstQuo", {32'd0, quotient}, 64'd0);
    checkVal("rstRem", {32'd0, remainder}, 64'd0);
    checkVal("rstStall", {63'd0, div_stall}, 64'd0);
    checkVal("rstValid", {63'd0, result_valid}, 64'd0);
    @(posedge clk); #1; resetn = 1'b1;

    runDiv(1'b0, 32'd100, 32'd7, 0);
    runDiv(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    runDiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    runDiv(1'b0, 32'd5, 32'd0, 0);
    runDiv(1'b1, 32'hFFFF_FFFB, 32'd0, 0);
    runDiv(1'b1, 32'd3, 32'hFFFF_FFF9, 0);
    runDiv(1'b0, 32'hFFFF_FFFF, 32'd1, 0);

    // Annul on BUSY cycle 10, then a fresh divide.
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; a = 32'd1000; b = 32'd3;
    repeat (10) @(posedge clk);
    #1; annul = 1'b1;
    @(negedge clk);
    checkVal("annulStall", {63'd0, div_stall}, 64'd0);
    checkVal("annulValid", {63'd0, result_valid}, 64'd0);
    @(posedge clk); #1; annul = 1'b0; start = 1'b0;
    @(negedge clk);
    checkVal("postAnnulStall", {63'd0, div_stall}, 64'd0);
    runDiv(1'b0, 32'd9, 32'd4, 0);

    // start together with annul must not begin a divide.
    @(posedge clk); #1; start = 1'b1; annul = 1'b1; a = 32'd77; b = 32'd5;
    @(negedge clk);
    checkVal("startAnnulStall", {63'd0, div_stall}, 64'd0);
    @(posedge clk); #1; start = 1'b0; annul = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkVal("startAnnulValid", {63'd0, result_valid}, 64'd0);
    checkVal("startAnnulStall2", {63'd0, div_stall}, 64'd0);

    runDiv(1'b0, 32'd50, 32'd5, 5);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] rx, ry;
      rx = $urandom;
      ry = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      runDiv(1'(i % 3 == 0), rx, ry, 0);
    end

    runDiv(1'b0, 32'd50, 32'd5, 0);
    // Asynchronous reset in the middle of BUSY.
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; a = 32'd1000; b = 32'd3;
    repeat (5) @(posedge clk);
    #3; resetn = 1'b0;
    #1;
    checkVal("midRstQuo", {32'd0, quotient}, 64'd0);
    checkVal("midRstRem", {32'd0, remainder}, 64'd0);
    checkVal("midRstStall", {63'd0, div_stall}, 64'd0);
    checkVal("midRstValid", {63'd0, result_valid}, 64'd0);
    start = 1'b0;
    @(posedge clk); #1; resetn = 1'b1;
    runDiv(1'b0, 32'd1000, 32'd3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule

// File: doc/mips_div_iter.md
Name: mips_div_iter

Overview:
- Iterative radix-2 restoring divider in the E stage of the 5-stage MIPS core.
- Handles DIV and DIVU; results go to HI (remainder) and LO (quotient).
- Produces the divider-busy stall (div_stallE) consumed by the hazard unit.
- Honours the hazard unit's flush (exception) and the other-source hold, so a divide is never restarted or lost while E is frozen.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  core clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  valid DIV/DIVU instruction present in E stage.
- signed_div  in  1  1 = DIV (signed), 0 = DIVU.
- a  in  WIDTH  dividend (rs, post-forwarding).
- b  in  WIDTH  divisor (rt, post-forwarding).
- annul  in  1  flush of E (exception in M); kills any operation in flight.
- hold  in  1  E stage frozen by a non-divider source (i_stall|d_stall).
- div_stall  out  1  divider busy; E and earlier stages must not advance.
- result_valid  out  1  quotient/remainder valid for the instruction in E.
- quotient  out  WIDTH  LO value.
- remainder  out  WIDTH  HI value.

Behaviour:
- Reset (async, resetn=0):
  - State IDLE; counter 0; quotient 0; remainder 0.
  - div_stall 0; result_valid 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - div_stall = start & ~annul (combinational), so E is held in the same cycle the divide is seen.
  - On start & ~annul: latch |a| and |b| (magnitudes if signed_div, raw values otherwise).
  - Also latch sign_q = a[MSB]^b[MSB] and sign_r = a[MSB], both forced 0 when unsigned.
  - Clear the partial remainder and counter, then go to BUSY.
- BUSY:
  - div_stall = 1.
  - One restoring step per cycle: shift {rem,quo} left 1; trial = rem - divisor.
  - If the trial is non-negative, rem = trial and the quo LSB = 1.
  - Counter increments; after WIDTH steps (counter == WIDTH-1 at the edge), go to DONE.
  - Sign fix-up is applied on entry to DONE, so quotient/remainder are final in the first DONE cycle.
- DONE:
  - div_stall = 0; result_valid = 1; quotient/remainder are stable.
  - While hold = 1, stay in DONE. start remains high for the same instruction and must not restart.
  - When hold = 0, E advances and the state returns to IDLE at the next edge.
  - A new start can be accepted only from IDLE, i.e. no earlier than the cycle after E advances.
- Latency:
  - div_stall is high for 1 (IDLE accept cycle) + WIDTH (BUSY) = 33 cycles.
  - result_valid rises on cycle 34 counted from start.
- Sign rules:
  - Quotient is negated if sign_q.
  - Remainder is negated if sign_r (takes the dividend's sign; truncation toward zero).
  - Signed -2^31 / -1 gives quotient 0x80000000, remainder 0 (wraps, no trap).
- Divide by zero: no special casing. Natural restoring result: quotient all ones (before sign fix-up), remainder = |a| (before sign fix-up).
- Annul:
  - Overrides everything in any state: div_stall and result_valid are forced to 0 in the same cycle.
  - Next state is IDLE; quotient/remainder keep their stale values.
  - start & annul in the same cycle does not begin a divide.
- hold during BUSY has no effect; iteration continues.
- Reset asserted mid-operation aborts immediately to the reset values.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined:
  - In IDLE on start & ~annul, if |b| == 0 or |a| < |b| (unsigned magnitude compare), go straight to DONE, skipping BUSY.
  - Result in that case: quotient 0 and remainder a (as given); for b == 0, quotient all ones (sign-fixed) and remainder a.
  - div_stall is high for exactly 1 cycle.
- Undefined: always full WIDTH-step latency; no magnitude comparator is instantiated.

Test Plan:
- DIVU a=100, b=7, hold=0:
  - div_stall high exactly 33 cycles.
  - Then result_valid=1 with quotient=14, remainder=2; IDLE one cycle later.
- DIV a=0xFFFFFFF9 (-7), b=2 → quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
- DIV a=0x80000000, b=0xFFFFFFFF → quotient=0x80000000, remainder=0.
- DIVU a=5, b=0:
  - Without the macro: 33 stall cycles, quotient=0xFFFFFFFF, remainder=5.
  - With DIV_EARLY_OUT_EN: 1 stall cycle, same values.
- Start DIVU 1000/3, assert annul on BUSY cycle 10:
  - div_stall low that cycle; IDLE next cycle.
  - A following start 9/4 completes with quotient=2, remainder=1.
- DIVU 50/5 reaching DONE with hold=1 for 5 cycles and start held high:
  - result_valid stays 1, quotient=10, remainder=0, no restart.
  - After hold drops: IDLE; pulsing resetn low mid-BUSY on a later divide clears all outputs asynchronously.
